wheel_pwm_driver: RTL and testbench
===================================

# wheel_pwm_driver

Converts the four wheel angular-velocity targets from the inverse-kinematics stage into H-bridge drive signals: one PWM line and one direction line per wheel. It sits directly downstream of the movement controller and directly drives the motor-driver pins. Duty and direction update only at PWM period boundaries, through shadow registers. A reversal request inserts a brake interval of whole periods before the new direction is applied.

## Interface

**Parameters**
- `PWM_BITS`, default 10: phase-counter width; period = 2^PWM_BITS clocks (1024 clocks ≈ 48.8 kHz at 50 MHz).
- `DUTY_SHIFT`, default 3: right shift from Q8 magnitude to duty counts.
- `DEADBAND`, default 16: magnitudes below this value (Q8; 16 = 0.0625 rad/s) produce duty 0.
- `BRAKE_PERIODS`, default 2: whole periods with PWM low on a direction reversal; must be ≥ 1.

**Ports**
- `WHEEL_PWM_DRIVER_CLOCK_50`, in, 1: system clock; the single clock.
- `WHEEL_PWM_DRIVER_RESET_InHigh`, in, 1: reset, synchronous, active-high.
- `WHEEL_PWM_DRIVER_ENABLE_InHigh`, in, 1: drive enable.
- `WHEEL_PWM_DRIVER_W1_InBus` … `WHEEL_PWM_DRIVER_W4_InBus`, in, 17 each: wheel targets in rad/s. Format is sign-magnitude: bit 16 is the sign (1 = negative), bits 15:0 are the magnitude with 8 fractional bits.
- `WHEEL_PWM_DRIVER_PWM_OutBus`, out, 4: PWM per wheel; bit i-1 = wheel i.
- `WHEEL_PWM_DRIVER_DIR_OutBus`, out, 4: applied direction; 1 = reverse.
- `WHEEL_PWM_DRIVER_SAT_OutBus`, out, 4: duty saturated in the current period.
- `WHEEL_PWM_DRIVER_SYNC_OutHigh`, out, 1: one-cycle strobe on the last phase of each period.

## Operation

**Phase counter**
- Free-running counter from 0 to 2^PWM_BITS−1, wrapping to 0.
- `SYNC_OutHigh` = 1 exactly when the phase equals 2^PWM_BITS−1.

**Sampling**
- On the clock edge that ends a SYNC cycle, each wheel's input is captured and processed:
  - m = bits 15:0.
  - If m < DEADBAND, then d = 0.
  - Otherwise d = m >> DUTY_SHIFT. If d > 2^PWM_BITS−1, then d = 2^PWM_BITS−1 and the wheel's sat flag = 1; otherwise sat flag = 0.
  - A request with d = 0 is a zero request. Its sign is ignored, including negative zero.

**Per-wheel FSM**, with states RUN and BRAKE. Each wheel holds an applied duty `D`, an applied direction `R`, and a brake count `C`.
- **RUN**, at a sample:
  - Zero request, or request sign equal to R: D ← d, R unchanged.
  - Nonzero request with sign ≠ R: go to BRAKE, D ← 0, C ← BRAKE_PERIODS, R unchanged.
- **BRAKE**, at each sample: C ← C−1.
  - When C becomes 0: go to RUN, R ← latest sign (if d ≠ 0), D ← latest d.
  - While C is nonzero, D stays 0.

**Output**
- PWM bit = 1 in the cycles whose phase < D; duty 2^PWM_BITS−1 leaves one low cycle per period.
- DIR shows R.
- SAT shows the sat flags from the latest sample.

**Enable low**
- PWM forced to 0 from the next cycle.
- At the next sample, every wheel goes to RUN with D = 0 and R = 0, and SAT = 0.
- The phase counter keeps running.
- Normal sampling resumes at the first sample taken with enable high.

## Timing

- **Reset:** on the reset edge the phase, D, R, C, SAT and PWM all become 0, DIR = 0, SYNC = 0, and every FSM is RUN.
- **After reset:** the first cycle after release is phase 0. The first SYNC comes in the 1024th cycle (PWM_BITS = 10).
- **Reset mid-operation:** overrides everything on that edge, including an active BRAKE.
- **Latency:** a sampled value drives PWM/DIR from phase 0 of the next period, i.e. the cycle after SYNC. An input change anywhere else in a period has no effect until the next sample.
- **Registering:** all outputs are registered; no combinational path from input to output.
- **Reversal:** PWM stays low for exactly BRAKE_PERIODS × 2^PWM_BITS cycles. DIR toggles in the same cycle the new duty takes effect.
- **Simultaneous events:** enable falling in a SYNC cycle means that sample is not taken and the enable-low clearing applies. Reset takes priority over enable.

## Test plan

1. **Reset:** hold reset 5 cycles, then release. PWM = DIR = SAT = 0000; SYNC first high 1024 cycles after release, then every 1024 cycles.
2. **Forward drive:** W1 = 0_00001010_00000000 (+10.0 rad/s, m = 2560). From the period after sampling, PWM[0] is high for 320 of every 1024 cycles, DIR[0] = 0, SAT[0] = 0.
3. **Saturated reverse:** W2 = 1_00101000_00000000 (−40 rad/s), starting from R = 0.
   - PWM[1] is low for 2048 cycles and DIR[1] stays 0.
   - Then DIR[1] = 1 and PWM[1] is high for 1023 of 1024 cycles; SAT[1] = 1 from the first sample on.
4. **Deadband and negative zero:** W3 = +15 (Q8) → duty 0. Then W3 = 1_0…0 → duty 0, no BRAKE, DIR[3-1] held.
5. **Mid-period change:** change W4 from +4.0 to +8.0 at phase 500. Duty stays 128 for the rest of that period and becomes 256 at the next phase 0.
6. **Interrupts:** deassert enable during a BRAKE → PWM = 0 next cycle, and DIR = 0 after the next SYNC. Repeat with reset asserted mid-BRAKE → all outputs 0 on the following edge.

Source files
------------

// File: rtl/wheel_pwm_driver.sv
// Four-wheel H-bridge PWM driver: sign-magnitude Q8 targets are sampled once per
// PWM period and applied through per-wheel RUN/BRAKE FSMs with reversal braking.
module wheel_pwm_driver #(
  parameter int PWM_BITS      = 10,
  parameter int DUTY_SHIFT    = 3,
  parameter int DEADBAND      = 16,
  parameter int BRAKE_PERIODS = 2
) (
  input  logic        WHEEL_PWM_DRIVER_CLOCK_50,
  input  logic        WHEEL_PWM_DRIVER_RESET_InHigh,
  input  logic        WHEEL_PWM_DRIVER_ENABLE_InHigh,
  input  logic [16:0] WHEEL_PWM_DRIVER_W1_InBus,
  input  logic [16:0] WHEEL_PWM_DRIVER_W2_InBus,
  input  logic [16:0] WHEEL_PWM_DRIVER_W3_InBus,
  input  logic [16:0] WHEEL_PWM_DRIVER_W4_InBus,
  output logic [3:0]  WHEEL_PWM_DRIVER_PWM_OutBus,
  output logic [3:0]  WHEEL_PWM_DRIVER_DIR_OutBus,
  output logic [3:0]  WHEEL_PWM_DRIVER_SAT_OutBus,
  output logic        WHEEL_PWM_DRIVER_SYNC_OutHigh
);

  // state | meaning
  // RUN   | applied duty D follows samples in the applied direction R
  // BRAKE | reversal pending: PWM held low for C more samples
  typedef enum logic {ST_RUN = 1'b0, ST_BRAKE = 1'b1} state_t;

  localparam int                  CW       = $clog2(BRAKE_PERIODS + 1);
  localparam logic [PWM_BITS-1:0] PH_MAX   = '1;
  localparam logic [15:0]         DUTY_MAX = 16'((32'd1 << PWM_BITS) - 32'd1);

  logic [PWM_BITS-1:0] r_phase;
  logic                r_sync;
  state_t              r_st  [4];
  logic [PWM_BITS-1:0] r_d   [4];
  logic [CW-1:0]       r_c   [4];
  logic [3:0]          r_r;
  logic [3:0]          r_sat;
  logic [3:0]          r_pwm;

  logic [16:0]         w_in    [4];
  logic [15:0]         w_shift [4];
  logic [PWM_BITS-1:0] w_d     [4];
  logic [3:0]          w_sat;
  logic [3:0]          w_neg;
  logic [3:0]          w_nz;
  logic                w_sample;
  logic [PWM_BITS-1:0] w_phase_nxt;

  assign w_in[0] = WHEEL_PWM_DRIVER_W1_InBus;
  assign w_in[1] = WHEEL_PWM_DRIVER_W2_InBus;
  assign w_in[2] = WHEEL_PWM_DRIVER_W3_InBus;
  assign w_in[3] = WHEEL_PWM_DRIVER_W4_InBus;

  assign w_sample    = (r_phase == PH_MAX);
  assign w_phase_nxt = r_phase + 1'b1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_shift[i] = w_in[i][15:0] >> DUTY_SHIFT;
      w_d[i]     = '0;
      w_sat[i]   = 1'b0;
      if (w_in[i][15:0] >= 16'(DEADBAND)) begin
        if (w_shift[i] > DUTY_MAX) begin
          w_d[i]   = PH_MAX;
          w_sat[i] = 1'b1;
        end else begin
          w_d[i] = w_shift[i][PWM_BITS-1:0];
        end
      end
      w_neg[i] = w_in[i][16];
      w_nz[i]  = (w_d[i] != '0);
    end
  end

  // PWM is registered from next-state values so a new duty shows up in phase 0.
  always_ff @(posedge WHEEL_PWM_DRIVER_CLOCK_50) begin
    if (WHEEL_PWM_DRIVER_RESET_InHigh) begin
      r_phase <= '0;
      r_sync  <= 1'b0;
      r_r     <= '0;
      r_sat   <= '0;
      r_pwm   <= '0;
      for (int i = 0; i < 4; i++) begin
        r_st[i] <= ST_RUN;
        r_d[i]  <= '0;
        r_c[i]  <= '0;
      end
    end else begin
      r_phase <= w_phase_nxt;
      r_sync  <= (w_phase_nxt == PH_MAX);
      for (int i = 0; i < 4; i++) begin
        if (w_sample) begin
          if (!WHEEL_PWM_DRIVER_ENABLE_InHigh) begin
            r_st[i]  <= ST_RUN;
            r_d[i]   <= '0;
            r_c[i]   <= '0;
            r_r[i]   <= 1'b0;
            r_sat[i] <= 1'b0;
            r_pwm[i] <= 1'b0;
          end else begin
            r_sat[i] <= w_sat[i];
            if (r_st[i] == ST_RUN) begin
              if (w_nz[i] && (w_neg[i] != r_r[i])) begin
                r_st[i]  <= ST_BRAKE;
                r_d[i]   <= '0;
                r_c[i]   <= CW'(BRAKE_PERIODS);
                r_pwm[i] <= 1'b0;
              end else begin
                r_d[i]   <= w_d[i];
                r_pwm[i] <= w_nz[i];
              end
            end else if (r_c[i] == CW'(1)) begin
              r_st[i]  <= ST_RUN;
              r_c[i]   <= '0;
              r_d[i]   <= w_d[i];
              r_pwm[i] <= w_nz[i];
              if (w_nz[i]) r_r[i] <= w_neg[i];
            end else begin
              r_c[i]   <= r_c[i] - 1'b1;
              r_pwm[i] <= 1'b0;
            end
          end
        end else begin
          r_pwm[i] <= WHEEL_PWM_DRIVER_ENABLE_InHigh && (w_phase_nxt < r_d[i]);
        end
      end
    end
  end

  assign WHEEL_PWM_DRIVER_PWM_OutBus   = r_pwm;
  assign WHEEL_PWM_DRIVER_DIR_OutBus   = r_r;
  assign WHEEL_PWM_DRIVER_SAT_OutBus   = r_sat;
  assign WHEEL_PWM_DRIVER_SYNC_OutHigh = r_sync;

endmodule

// File: tb/tb_wheel_pwm_driver.sv
// Directed bench for wheel_pwm_driver: per-period duty counts, braking,
// deadband, mid-period changes, enable-low clearing and reset.
module tb_wheel_pwm_driver;

  logic        clk_sys;
  logic        rst;
  logic        en;
  logic [16:0] w1, w2, w3, w4;
  logic [3:0]  pwm, dir, sat;
  logic        sync;

  int          n_tests;
  int          n_fail;
  int          hi [4];
  logic [3:0]  pwm0, dir0, sat0;
  int          last_hi0;
  int          n;

  wheel_pwm_driver dut (
    .WHEEL_PWM_DRIVER_CLOCK_50     (clk_sys),
    .WHEEL_PWM_DRIVER_RESET_InHigh (rst),
    .WHEEL_PWM_DRIVER_ENABLE_InHigh(en),
    .WHEEL_PWM_DRIVER_W1_InBus     (w1),
    .WHEEL_PWM_DRIVER_W2_InBus     (w2),
    .WHEEL_PWM_DRIVER_W3_InBus     (w3),
    .WHEEL_PWM_DRIVER_W4_InBus     (w4),
    .WHEEL_PWM_DRIVER_PWM_OutBus   (pwm),
    .WHEEL_PWM_DRIVER_DIR_OutBus   (dir),
    .WHEEL_PWM_DRIVER_SAT_OutBus   (sat),
    .WHEEL_PWM_DRIVER_SYNC_OutHigh (sync)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at the negedge of a SYNC cycle; observes the following full period.
  task automatic run_period(input int chg_at, input logic [16:0] chg_val);
    for (int b = 0; b < 4; b++) hi[b] = 0;
    last_hi0 = -1;
    for (int p = 0; p < 1024; p++) begin
      @(negedge clk_sys);
      if (p == 0) begin
        pwm0 = pwm;
        dir0 = dir;
        sat0 = sat;
      end
      for (int b = 0; b < 4; b++) if (pwm[b]) hi[b]++;
      if (pwm[0]) last_hi0 = p;
      if (p == chg_at) w4 = chg_val;
    end
    chk("sync_period_end", 32'(sync), 32'd1);
  endtask

  task automatic wait_sync();
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!sync && n < 2100);
    chk("sync_wait", 32'(sync), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    en  = 1'b1;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0;

    // reset and SYNC cadence
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b0;
    chk("rst_pwm",  32'(pwm),  32'd0);
    chk("rst_dir",  32'(dir),  32'd0);
    chk("rst_sat",  32'(sat),  32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    n = 1;
    while (!sync && n < 2100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("sync_first", 32'(n), 32'd1024);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!sync && n < 2100);
    chk("sync_interval", 32'(n), 32'd1024);

    // forward drive +10.0 rad/s
    w1 = 17'h00A00;
    run_period(-1, '0);
    chk("fwd_hi0",    32'(hi[0]),    32'd320);
    chk("fwd_last0",  32'(last_hi0), 32'd319);
    chk("fwd_first0", 32'(pwm0[0]),  32'd1);
    chk("fwd_dir",    32'(dir0),     32'd0);
    chk("fwd_sat",    32'(sat0),     32'd0);
    chk("fwd_hi1",    32'(hi[1]),    32'd0);

    // saturated reverse -40 rad/s on wheel 2
    w2 = 17'h12800;
    run_period(-1, '0);
    chk("rev_b1_hi1",  32'(hi[1]),   32'd0);
    chk("rev_b1_dir1", 32'(dir0[1]), 32'd0);
    chk("rev_b1_sat1", 32'(sat0[1]), 32'd1);
    chk("rev_b1_hi0",  32'(hi[0]),   32'd320);
    run_period(-1, '0);
    chk("rev_b2_hi1",  32'(hi[1]),   32'd0);
    chk("rev_b2_dir1", 32'(dir0[1]), 32'd0);
    run_period(-1, '0);
    chk("rev_run_hi1",  32'(hi[1]),   32'd1023);
    chk("rev_run_pwm1", 32'(pwm0[1]), 32'd1);
    chk("rev_run_dir1", 32'(dir0[1]), 32'd1);
    chk("rev_run_sat1", 32'(sat0[1]), 32'd1);

    // deadband, then zero requests of either sign
    w3 = 17'h0000F;
    run_period(-1, '0);
    chk("db15_hi2", 32'(hi[2]), 32'd0);
    w3 = 17'h10000;
    w2 = 17'h00000;
    run_period(-1, '0);
    chk("nz_hi2",  32'(hi[2]),   32'd0);
    chk("nz_dir2", 32'(dir0[2]), 32'd0);
    chk("pz_hi1",  32'(hi[1]),   32'd0);
    chk("pz_dir1", 32'(dir0[1]), 32'd1);
    chk("pz_sat1", 32'(sat0[1]), 32'd0);
    w3 = 17'h00800;
    w2 = 17'h10800;
    w1 = 17'h00010;
    w4 = 17'h00400;
    run_period(-1, '0);
    chk("nobrake_hi2", 32'(hi[2]),   32'd256);
    chk("nobrake_hi1", 32'(hi[1]),   32'd256);
    chk("nobrake_dir", 32'(dir0),    32'd2);
    chk("db16_hi0",    32'(hi[0]),   32'd2);
    chk("w4_hi3",      32'(hi[3]),   32'd128);

    // mid-period change on wheel 4
    run_period(500, 17'h00800);
    chk("mid_same_hi3", 32'(hi[3]), 32'd128);
    run_period(-1, '0);
    chk("mid_next_hi3", 32'(hi[3]), 32'd256);

    // enable low during a brake
    w1 = 17'h10A00;
    w2 = 17'h12800;
    for (int p = 0; p <= 100; p++) begin
      @(negedge clk_sys);
      if (p == 0) begin
        chk("en_pre_dir", 32'(dir), 32'd2);
        chk("en_pre_sat", 32'(sat), 32'd2);
      end
    end
    chk("en_pre_pwm", 32'(pwm), 32'd14);
    en = 1'b0;
    @(negedge clk_sys);
    chk("en_low_pwm", 32'(pwm), 32'd0);
    chk("en_low_dir", 32'(dir), 32'd2);
    wait_sync();
    @(negedge clk_sys);
    chk("en_clr_dir", 32'(dir), 32'd0);
    chk("en_clr_sat", 32'(sat), 32'd0);
    chk("en_clr_pwm", 32'(pwm), 32'd0);
    en = 1'b1;
    wait_sync();

    // reset in the middle of a brake
    for (int p = 0; p <= 50; p++) @(negedge clk_sys);
    chk("rb_pre_pwm", 32'(pwm), 32'd12);
    chk("rb_pre_sat", 32'(sat), 32'd2);
    rst = 1'b1;
    @(negedge clk_sys);
    chk("rb_pwm",  32'(pwm),  32'd0);
    chk("rb_dir",  32'(dir),  32'd0);
    chk("rb_sat",  32'(sat),  32'd0);
    chk("rb_sync", 32'(sync), 32'd0);
    @(negedge clk_sys);
    rst = 1'b0;
    n = 1;
    while (!sync && n < 2100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("rb_sync_first", 32'(n), 32'd1024);
    run_period(-1, '0);
    chk("rb_post_hi3",  32'(hi[3]), 32'd256);
    chk("rb_post_hi0",  32'(hi[0]), 32'd0);
    chk("rb_post_hi1",  32'(hi[1]), 32'd0);
    chk("rb_post_dir",  32'(dir0),  32'd0);
    chk("rb_post_sat1", 32'(sat0[1]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
